// File: rtl/fabric_rx_dispatcher.sv
// fabric_rx_dispatcher
// ---------------------------------------------------------------------------
// Per-ingress-port dispatch engine in the fabric clock domain. It sits right
// after the fabric side of the port RX FIFO. For each head frame it:
//   - issues a MAC/VLAN lookup,
//   - removes this port from the returned egress mask (no hairpinning),
//   - floods the frame if the lookup does not answer in time,
//   - requests the crossbar and, once granted, streams the frame words to it,
//   - pops the frame from the RX FIFO.
//
// Parameters
//   PORT_COUNT      number of switch ports (width of the port masks)
//   PORT_ID         index of this ingress port
//   LOOKUP_TIMEOUT  cycles to wait for lookup_done before flooding (>= 1)
//
// Optional feature macro
//   FABRIC_RX_DISPATCH_LEARN_EN  when defined, a source-MAC learning request is
//                                issued with each lookup. Group source MACs
//                                (bit 40 set) are not learned. When the macro
//                                is undefined, learn_* outputs are tied to 0.
//
// Ports
//   fabric_clk, fabric_rst_n            clock; asynchronous active-low reset
//   rx_frame_valid / _dst_mac /
//     _src_mac / _vlan                  head-frame headers from the RX FIFO
//   rx_fwd_en                           pulse: start reading frame data
//   rx_fwd_valid / _bytes_valid /
//     _data / _last                     frame word stream from the RX FIFO
//   rx_pop                              pulse: discard the head frame
//   lookup_req / _dst_mac / _vlan       lookup request and key
//   lookup_done / lookup_port_mask      lookup result
//   xbar_req / xbar_port_mask           crossbar request and egress mask
//   xbar_grant                          crossbar grant (level)
//   xbar_valid / _bytes_valid /
//     _data / _last                     egress word stream to the crossbar
//   learn_valid / _mac / _vlan          source learning request
//   perf_forwarded / _dropped /
//     _flooded                          one-cycle event pulses
// ---------------------------------------------------------------------------
module fabric_rx_dispatcher #(
  parameter int PORT_COUNT     = 8,
  parameter int PORT_ID        = 0,
  parameter int LOOKUP_TIMEOUT = 63
) (
  input  logic                  fabric_clk,
  input  logic                  fabric_rst_n,
  input  logic                  rx_frame_valid,
  input  logic [47:0]           rx_frame_dst_mac,
  input  logic [47:0]           rx_frame_src_mac,
  input  logic [11:0]           rx_frame_vlan,
  output logic                  rx_fwd_en,
  input  logic                  rx_fwd_valid,
  input  logic [3:0]            rx_fwd_bytes_valid,
  input  logic [63:0]           rx_fwd_data,
  input  logic                  rx_fwd_last,
  output logic                  rx_pop,
  output logic                  lookup_req,
  output logic [47:0]           lookup_dst_mac,
  output logic [11:0]           lookup_vlan,
  input  logic                  lookup_done,
  input  logic [PORT_COUNT-1:0] lookup_port_mask,
  output logic                  xbar_req,
  output logic [PORT_COUNT-1:0] xbar_port_mask,
  input  logic                  xbar_grant,
  output logic                  xbar_valid,
  output logic [3:0]            xbar_bytes_valid,
  output logic [63:0]           xbar_data,
  output logic                  xbar_last,
  output logic                  learn_valid,
  output logic [47:0]           learn_mac,
  output logic [11:0]           learn_vlan,
  output logic                  perf_forwarded,
  output logic                  perf_dropped,
  output logic                  perf_flooded
);

  localparam int CNT_W = (LOOKUP_TIMEOUT < 2) ? 1 : $clog2(LOOKUP_TIMEOUT + 1);
  localparam logic [PORT_COUNT-1:0] ONE_MASK  = PORT_COUNT'(1);
  localparam logic [PORT_COUNT-1:0] SELF_MASK = ONE_MASK << PORT_ID;
  // Counter value during the last cycle a lookup answer is still accepted;
  // the flood decision taken at the end of that cycle becomes visible exactly
  // LOOKUP_TIMEOUT cycles after lookup_req.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LOOKUP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_ARB, S_FORWARD, S_POP, S_HOLDOFF
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [PORT_COUNT-1:0] r_mask;
  logic [PORT_COUNT-1:0] w_new_mask;
  logic                  w_decide;
  logic                  r_lookup_req;
  logic [47:0]           r_dst_mac;
  logic [11:0]           r_vlan;
  logic                  r_xbar_req;
  logic                  r_rx_fwd_en;
  logic                  r_fwd_flag;
  logic                  r_xbar_valid;
  logic [3:0]            r_xbar_bytes;
  logic [63:0]           r_xbar_data;
  logic                  r_xbar_last;
  logic                  r_perf_dropped;
  logic                  r_perf_flooded;

  // A lookup answer in the timeout cycle takes priority over flooding.
  assign w_decide   = lookup_done || (r_cnt == CNT_LAST);
  assign w_new_mask = lookup_done ? (lookup_port_mask & ~SELF_MASK) : ~SELF_MASK;

  always_ff @(posedge fabric_clk or negedge fabric_rst_n) begin
    if (!fabric_rst_n) r_state <= S_IDLE;
    else               r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (rx_frame_valid) w_state_next = S_LOOKUP;
      S_LOOKUP:  if (w_decide) w_state_next = (w_new_mask == '0) ? S_POP : S_ARB;
      S_ARB:     if (xbar_grant) w_state_next = S_FORWARD;
      S_FORWARD: if (rx_fwd_valid && rx_fwd_last) w_state_next = S_POP;
      S_POP:     w_state_next = S_HOLDOFF;
      S_HOLDOFF: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge fabric_clk or negedge fabric_rst_n) begin
    if (!fabric_rst_n) begin
      r_cnt          <= '0;
      r_mask         <= '0;
      r_lookup_req   <= 1'b0;
      r_dst_mac      <= '0;
      r_vlan         <= '0;
      r_xbar_req     <= 1'b0;
      r_rx_fwd_en    <= 1'b0;
      r_fwd_flag     <= 1'b0;
      r_xbar_valid   <= 1'b0;
      r_xbar_bytes   <= '0;
      r_xbar_data    <= '0;
      r_xbar_last    <= 1'b0;
      r_perf_dropped <= 1'b0;
      r_perf_flooded <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      r_lookup_req   <= 1'b0;
      r_rx_fwd_en    <= 1'b0;
      r_xbar_valid   <= 1'b0;
      r_xbar_last    <= 1'b0;
      r_perf_dropped <= 1'b0;
      r_perf_flooded <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_frame_valid) begin
            r_dst_mac    <= rx_frame_dst_mac;
            r_vlan       <= rx_frame_vlan;
            r_lookup_req <= 1'b1;
            r_cnt        <= '0;
            r_fwd_flag   <= 1'b0;
          end
        end
        S_LOOKUP: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_decide) begin
            r_mask <= w_new_mask;
            if (!lookup_done)      r_perf_flooded <= 1'b1;
            if (w_new_mask == '0)  r_perf_dropped <= 1'b1;
            else                   r_xbar_req     <= 1'b1;
          end
        end
        S_ARB: begin
          if (xbar_grant) begin
            r_rx_fwd_en <= 1'b1;
            r_fwd_flag  <= 1'b1;
          end
        end
        S_FORWARD: begin
          if (rx_fwd_valid) begin
            r_xbar_valid <= 1'b1;
            r_xbar_bytes <= rx_fwd_bytes_valid;
            r_xbar_data  <= rx_fwd_data;
            r_xbar_last  <= rx_fwd_last;
          end
        end
        S_POP: begin
          // xbar_last is on the output during POP; release the crossbar after it.
          r_xbar_req <= 1'b0;
          r_mask     <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef FABRIC_RX_DISPATCH_LEARN_EN
  logic        r_learn_valid;
  logic [47:0] r_src_mac;

  always_ff @(posedge fabric_clk or negedge fabric_rst_n) begin
    if (!fabric_rst_n) begin
      r_learn_valid <= 1'b0;
      r_src_mac     <= '0;
    end else begin
      r_learn_valid <= 1'b0;
      if (r_state == S_IDLE && rx_frame_valid) begin
        r_src_mac     <= rx_frame_src_mac;
        // Group (multicast/broadcast) source addresses are never learned.
        r_learn_valid <= ~rx_frame_src_mac[40];
      end
    end
  end

  assign learn_valid = r_learn_valid;
  assign learn_mac   = r_src_mac;
  assign learn_vlan  = r_vlan;
`else
  logic w_unused_src;
  assign w_unused_src = ^rx_frame_src_mac;
  assign learn_valid  = 1'b0;
  assign learn_mac    = '0;
  assign learn_vlan   = '0;
`endif

  assign rx_fwd_en        = r_rx_fwd_en;
  assign rx_pop           = (r_state == S_POP);
  assign lookup_req       = r_lookup_req;
  assign lookup_dst_mac   = r_dst_mac;
  assign lookup_vlan      = r_vlan;
  assign xbar_req         = r_xbar_req;
  assign xbar_port_mask   = r_mask;
  assign xbar_valid       = r_xbar_valid;
  assign xbar_bytes_valid = r_xbar_bytes;
  assign xbar_data        = r_xbar_data;
  assign xbar_last        = r_xbar_last;
  assign perf_forwarded   = (r_state == S_POP) && r_fwd_flag;
  assign perf_dropped     = r_perf_dropped;
  assign perf_flooded     = r_perf_flooded;

endmodule

// File: doc/fabric_rx_dispatcher.md
# fabric_rx_dispatcher

Per-ingress-port dispatch engine in the fabric_clk domain, directly downstream of the port RX FIFO's fabric-side interface. Takes the head frame's headers, issues a MAC/VLAN lookup, filters the resulting egress port mask, and arbitrates for the crossbar. It then streams the frame's 64-bit words into the crossbar and pops the frame from the RX FIFO.

## Interface
- PORT_COUNT, 8, number of switch ports (width of port masks)
- PORT_ID, 0, index of this ingress port (0..PORT_COUNT-1)
- LOOKUP_TIMEOUT, 63, cycles to wait for lookup_done before flooding (≥1)

- fabric_clk  in  1  fabric clock; all logic on rising edge
- fabric_rst_n  in  1  reset, asynchronous assert, active low
- rx_frame_valid  in  1  RX FIFO has a head frame; headers valid
- rx_frame_dst_mac / rx_frame_src_mac  in  48  head-frame MACs
- rx_frame_vlan  in  12  head-frame VLAN
- rx_fwd_en  out  1  one-cycle pulse: start reading frame data
- rx_fwd_valid  in  1  data word valid
- rx_fwd_bytes_valid  in  4  valid bytes in word (1..8)
- rx_fwd_data  in  64  frame data
- rx_fwd_last  in  1  qualifies final word of frame
- rx_pop  out  1  one-cycle pulse: discard head frame
- lookup_req  out  1  one-cycle lookup request
- lookup_dst_mac  out  48, lookup_vlan  out  12  lookup key, held from lookup_req until lookup_done or timeout
- lookup_done  in  1  result strobe; lookup_port_mask  in  PORT_COUNT
- xbar_req  out  1  crossbar request; xbar_port_mask  out  PORT_COUNT
- xbar_grant  in  1  crossbar grant (level)
- xbar_valid  out  1, xbar_bytes_valid  out  4, xbar_data  out  64, xbar_last  out  1  egress word stream
- learn_valid  out  1, learn_mac  out  48, learn_vlan  out  12  learning request (see Configuration)
- perf_forwarded, perf_dropped, perf_flooded  out  1 each  one-cycle event pulses

## Operation
- States: IDLE, LOOKUP, ARB, FORWARD, POP, HOLDOFF.
- IDLE: on rx_frame_valid, latch dst/src MAC and VLAN; pulse lookup_req; clear timeout counter; → LOOKUP.
- LOOKUP: counter increments each cycle. On lookup_done: mask = lookup_port_mask & ~(1<<PORT_ID). If counter reaches LOOKUP_TIMEOUT first: mask = all ones & ~(1<<PORT_ID), pulse perf_flooded. A lookup_done arriving in the timeout cycle wins; no flood. Then: mask==0 → pulse perf_dropped, → POP without reading data; else → ARB.
- ARB: xbar_req=1, xbar_port_mask=mask. On xbar_grant sampled high: pulse rx_fwd_en, → FORWARD.
- FORWARD: each rx_fwd_valid word is registered onto xbar_valid/bytes_valid/data/last (xbar_last = rx_fwd_last). On a word with rx_fwd_last: → POP. xbar_req and xbar_port_mask are held through the cycle xbar_last is output.
- POP: pulse rx_pop; pulse perf_forwarded if the frame was forwarded; → HOLDOFF.
- HOLDOFF: one cycle, rx_frame_valid ignored (upstream header refresh); → IDLE.
- rx_fwd_valid outside FORWARD is ignored. Grant loss in FORWARD is not supported; the crossbar holds grant until xbar_last.

## Timing
- Reset: state IDLE. All outputs 0, including masks, data, and lookup key. Reset mid-frame abandons the frame without rx_pop; the RX FIFO side is reset alongside.
- lookup_req asserts 1 cycle after rx_frame_valid is sampled in IDLE.
- rx_fwd_en asserts the cycle after xbar_grant is sampled.
- Data latency rx_fwd_* → xbar_*: exactly 1 cycle; no bubbles are inserted.
- rx_pop asserts 1 cycle after the last-word input; the earliest next lookup_req is 3 cycles after rx_pop.
- Timeout flood: mask is applied LOOKUP_TIMEOUT cycles after lookup_req.

## Configuration
- FABRIC_RX_DISPATCH_LEARN_EN defined: learn_valid pulses in the same cycle as lookup_req, with learn_mac=src MAC and learn_vlan=VLAN. Exception: no pulse if src MAC bit 40 (group bit) is set.
- Not defined: learn_valid, learn_mac, and learn_vlan are tied 0. The ports remain present.

## Test plan
- Unicast: PORT_ID=0, lookup returns 8'h04 after 3 cycles, grant immediate, 3-word frame with last bytes_valid=4 → xbar_port_mask=8'h04. Three xbar words, 1-cycle delayed, xbar_last on the third. rx_pop and perf_forwarded once.
- Hairpin filter: lookup returns 8'h01 with PORT_ID=0 → no xbar_req, no rx_fwd_en, rx_pop and perf_dropped pulse.
- Timeout: lookup_done never arrives, LOOKUP_TIMEOUT=63 → at cycle 63, perf_flooded pulses and xbar_port_mask=8'hFE. Frame forwards normally.
- Grant stall: xbar_grant withheld 20 cycles → xbar_req held and rx_fwd_en low throughout. rx_fwd_en pulses the cycle after grant.
- Reset mid-FORWARD: fabric_rst_n low after word 2 → all outputs 0 immediately, state IDLE, no rx_pop.
- Learning: with macro, src 02:00:00:00:00:01 → learn_valid with that MAC. With src 01:00:5E:00:00:01 → no learn_valid. Without macro, learn_valid is never asserted.
